selevy_state_dump: RTL and testbench
====================================

Name: selevy_state_dump

Overview:
- Parametrised architectural-state dump engine for the selevy core. Replaces fixed bench-side loops over rf and rom with a synthesizable streamer.
- On a start pulse it walks a window of either the register file or the ROM through a generic 1-cycle-latency read port. Each word is emitted on a valid/ready stream carrying its index, for a trace sink or debug UART.
- Sits beside the selevy top, sharing CLK with regfile and rom.

Parameters:
- XLEN, 32, data word width.
- NREGS, 32, register file depth; register 0 is included in dumps.
- ROM_WORDS, 256, ROM depth in words.
- AW, 8, address/index width; must satisfy 2**AW >= max(NREGS, ROM_WORDS).

Ports:
- CLK  in  1  clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- mode  in  1  0 = register file, 1 = ROM; sampled with start.
- base  in  AW  first index; sampled with start.
- count  in  AW+1  number of words; sampled with start.
- abort  in  1  cancels the dump in progress.
- rd_en  out  1  read strobe.
- rd_sel  out  1  target of the read: 0 = rf, 1 = rom.
- rd_addr  out  AW  read index.
- rd_data  in  XLEN  read data, valid exactly 1 cycle after rd_en.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- out_data  out  XLEN  dumped word.
- out_index  out  AW  index of out_data.
- out_last  out  1  marks the final word of the window.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last word is accepted.
- err  out  1  one-cycle pulse on a rejected request.

Behaviour:
- Reset (async assert, sync deassert to the design): state=IDLE. rd_en, out_valid, out_last, busy, done and err are 0. rd_addr, out_data and out_index are 0.
- FSM states: IDLE, READ, CAPTURE, SEND, FIN.
- IDLE + start:
  - Request is legal when count != 0 and base + count <= depth, where depth = NREGS for mode 0 and ROM_WORDS for mode 1. Compute the sum at AW+2 bits so it cannot wrap.
  - Illegal request: err=1 for 1 cycle, remain in IDLE.
  - Legal request: latch mode/base/count, set ptr=base and remaining=count, go to READ.
- READ: rd_en=1, rd_sel=mode, rd_addr=ptr for exactly 1 cycle -> CAPTURE.
- CAPTURE: register rd_data into out_data and ptr into out_index. Assert out_valid; out_last = (remaining==1). -> SEND.
- SEND:
  - Hold out_data, out_index and out_last stable while out_valid && !out_ready.
  - On handshake (out_valid && out_ready), decrement remaining and increment ptr.
  - If out_last, -> FIN; otherwise -> READ.
  - out_valid drops on the cycle after the handshake.
- FIN: done=1 for 1 cycle -> IDLE.
- Timing:
  - Throughput is 1 word per 3 cycles with out_ready held high.
  - Latency from start to first out_valid is 2 cycles (READ, CAPTURE).
- abort:
  - Effective in any state except IDLE; it has priority over a handshake in the same cycle.
  - Next state is IDLE with out_valid=0, rd_en=0 and no done pulse.
  - A word presented in that cycle counts as not transferred.
- start while busy is ignored; no err.
- start and abort in the same IDLE cycle: start wins and abort is ignored.
- Top-of-range window (base + count == depth): legal. ptr reaches depth-1 and never wraps.
- count == depth, base == 0: full dump, accepted.
- Reset mid-dump: outputs return to reset values immediately; no done or err.

Decomposition:
- Package selevy_dump_pkg holds:
  - the FSM state enum (3-bit encoding);
  - the mode constants MODE_RF=0 and MODE_ROM=1;
  - the width helper for the depth check.
- Sub-module selevy_dump_out_reg: the output holding register with valid/ready skid-free hold logic.
- A read-port mux feeding regfile/rom sits in the selevy top, not in this block.

Test Plan:
- Full rf dump (NREGS=32): reset_n low then high, start mode=0 base=0 count=32, out_ready=1, memory model rf[i]=i*3.
  - Required: 32 beats with out_index 0..31 and out_data 0,3,..,93.
  - out_last only on index 31; done 1 cycle after that beat; 96 cycles from first READ to FIN.
- ROM window with backpressure: mode=1 base=5 count=2, rom[5]=0xDEADBEEF, rom[6]=0x12345678, out_ready low for 4 cycles on beat 1.
  - Required: beat 1 held stable throughout the stall, then beat 2 with out_last=1, then done.
- Range errors:
  - mode=0 base=31 count=2 -> err pulse, busy stays 0, no rd_en.
  - count=0 -> err pulse.
  - mode=0 base=30 count=2 -> accepted, indices 30 and 31.
- Abort mid-stream: count=8, assert abort while beat 3 is valid with out_ready=1.
  - Required: beat 3 not counted, next cycle IDLE, out_valid=0, no done.
  - A fresh start is then accepted normally.
- Async reset mid-dump: drop reset_n between clock edges during SEND.
  - Required: out_valid and busy go 0 without waiting for CLK; start after release works.
- start while busy: second start mid-dump is ignored; the original window completes unchanged.

Source files
------------

// File: rtl/selevy_dump_pkg.sv
// Shared types for the selevy state-dump engine: FSM encoding, dump targets, and width helper.
// No logic here; latency and backpressure behaviour live in the modules that import it.
package selevy_dump_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    SEND    = 3'd3,
    FIN     = 3'd4
  } dump_state_t;

  localparam logic MODE_RF  = 1'b0;
  localparam logic MODE_ROM = 1'b1;

  // base + count needs two extra bits over AW so the range check cannot wrap
  function automatic int sum_width(input int aw);
    return aw + 2;
  endfunction

endpackage

// File: rtl/selevy_dump_out_reg.sv
// Output holding register for the dump stream; loads in 1 cycle, holds until handshake.
// Backpressure: data/index/last stay frozen while out_valid && !out_ready; flush drops valid.
module selevy_dump_out_reg #(
  parameter int XLEN = 32,
  parameter int AW   = 8
) (
  input  logic            CLK,
  input  logic            reset_n,
  input  logic            load,
  input  logic [XLEN-1:0] load_data,
  input  logic [AW-1:0]   load_index,
  input  logic            load_last,
  input  logic            flush,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] out_data,
  output logic [AW-1:0]   out_index,
  output logic            out_last
);

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_index <= load_index;
      out_last  <= load_last;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/selevy_state_dump.sv
// Streams a window of rf or rom out over valid/ready; 2 cycles start-to-valid, 1 word per 3 cycles.
// Backpressure: a presented word is held in SEND until accepted; abort drops it and returns to IDLE.
module selevy_state_dump
  import selevy_dump_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter int ROM_WORDS = 256,
  parameter int AW        = 8
) (
  input  logic            CLK,
  input  logic            reset_n,
  input  logic            start,
  input  logic            mode,
  input  logic [AW-1:0]   base,
  input  logic [AW:0]     count,
  input  logic            abort,
  output logic            rd_en,
  output logic            rd_sel,
  output logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] rd_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [AW-1:0]   out_index,
  output logic            out_last,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int SW = sum_width(AW);

  dump_state_t     state, state_nxt;
  logic            mode_q;
  logic [AW-1:0]   ptr;
  logic [AW:0]     remaining;
  logic            err_q;
  logic [SW-1:0]   depth;
  logic            legal;
  logic            kill;
  logic            hs;

  assign depth  = (mode == MODE_ROM) ? SW'(ROM_WORDS) : SW'(NREGS);
  assign legal  = (count != '0) && (({2'b00, base} + {1'b0, count}) <= depth);
  assign kill   = abort && (state != IDLE);
  assign hs     = (state == SEND) && out_valid && out_ready;
  assign busy   = (state != IDLE);
  assign rd_sel = mode_q;
  assign err    = err_q;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    rd_addr   = '0;
    done      = 1'b0;
    case (state)
      IDLE:    if (start && legal) state_nxt = READ;
      READ: begin
        rd_en     = 1'b1;
        rd_addr   = ptr;
        state_nxt = CAPTURE;
      end
      CAPTURE: state_nxt = SEND;
      SEND:    if (hs) state_nxt = out_last ? FIN : READ;
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (kill) begin
      state_nxt = IDLE;
      done      = 1'b0;
    end
  end

  // ptr stops on the last word so a top-of-range window never wraps it
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      mode_q    <= MODE_RF;
      ptr       <= '0;
      remaining <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= (state == IDLE) && start && !legal;
      if ((state == IDLE) && start && legal) begin
        mode_q    <= mode;
        ptr       <= base;
        remaining <= count;
      end else if (hs && !kill && !out_last) begin
        ptr       <= ptr + AW'(1);
        remaining <= remaining - (AW+1)'(1);
      end
    end
  end

  selevy_dump_out_reg #(
    .XLEN (XLEN),
    .AW   (AW)
  ) u_out_reg (
    .CLK        (CLK),
    .reset_n    (reset_n),
    .load       (state == CAPTURE),
    .load_data  (rd_data),
    .load_index (ptr),
    .load_last  (remaining == (AW+1)'(1)),
    .flush      (kill),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_index  (out_index),
    .out_last   (out_last)
  );

endmodule

// File: tb/tb_selevy_state_dump.sv
// Directed bench for selevy_state_dump with rf/rom models behind a 1-cycle read port.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_selevy_state_dump;

  logic        CLK       = 1'b0;
  logic        reset_n   = 1'b0;
  logic        start     = 1'b0;
  logic        mode      = 1'b0;
  logic [7:0]  base      = '0;
  logic [8:0]  count     = '0;
  logic        abort     = 1'b0;
  logic        out_ready = 1'b0;
  logic        rd_en, rd_sel, out_valid, out_last, busy, done, err;
  logic [7:0]  rd_addr, out_index;
  logic [31:0] rd_data = '0;
  logic [31:0] out_data;

  logic [31:0] rf  [256];
  logic [31:0] rom [256];

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  selevy_state_dump #(
    .XLEN(32), .NREGS(32), .ROM_WORDS(256), .AW(8)
  ) dut (
    .CLK       (CLK),
    .reset_n   (reset_n),
    .start     (start),
    .mode      (mode),
    .base      (base),
    .count     (count),
    .abort     (abort),
    .rd_en     (rd_en),
    .rd_sel    (rd_sel),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always @(posedge CLK) begin
    if (rd_en) rd_data <= rd_sel ? rom[rd_addr] : rf[rd_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic req(input logic m, input logic [7:0] b, input logic [8:0] c);
    mode  = m;
    base  = b;
    count = c;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // entered in READ with out_ready high; leaves in the cycle after the handshake
  task automatic beat(input logic [7:0] idx, input logic [31:0] dat, input logic last, input logic sel);
    chk("rd_en", rd_en, 1);
    chk("rd_addr", rd_addr, idx);
    chk("rd_sel", rd_sel, sel);
    chk("valid_in_read", out_valid, 0);
    step();
    chk("valid_in_capture", out_valid, 0);
    chk("rd_en_capture", rd_en, 0);
    step();
    chk("valid_in_send", out_valid, 1);
    chk("out_index", out_index, idx);
    chk("out_data", out_data, dat);
    chk("out_last", out_last, last);
    step();
  endtask

  task automatic fin_check();
    chk("done_pulse", done, 1);
    chk("busy_fin", busy, 1);
    step();
    chk("done_clear", done, 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      rf[i]  = 32'(i * 3);
      rom[i] = 32'hA500_0000 + 32'(i);
    end
    rom[5] = 32'hDEADBEEF;
    rom[6] = 32'h12345678;

    #3;
    chk("rst_rd_en", rd_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_index", out_index, 0);
    step();
    step();
    reset_n = 1'b1;
    step();
    chk("post_rst_busy", busy, 0);

    // full rf dump: 32 beats, 96 cycles READ..FIN
    out_ready = 1'b1;
    req(1'b0, 8'd0, 9'd32);
    chk("rf_busy", busy, 1);
    for (int k = 0; k < 32; k++) beat(8'(k), 32'(k * 3), k == 31, 1'b0);
    fin_check();

    // rom window with a 4-cycle stall on beat 1
    out_ready = 1'b0;
    req(1'b1, 8'd5, 9'd2);
    chk("rom_rd_addr", rd_addr, 5);
    chk("rom_rd_sel", rd_sel, 1);
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_index", out_index, 5);
      chk("stall_data", out_data, 32'hDEADBEEF);
      chk("stall_last", out_last, 0);
      step();
    end
    chk("stall_hold_final", out_data, 32'hDEADBEEF);
    out_ready = 1'b1;
    step();
    chk("post_hs_valid", out_valid, 0);
    beat(8'd6, 32'h12345678, 1'b1, 1'b1);
    fin_check();

    // range errors
    req(1'b0, 8'd31, 9'd2);
    chk("err_over", err, 1);
    chk("err_over_busy", busy, 0);
    chk("err_over_rd_en", rd_en, 0);
    step();
    chk("err_clear", err, 0);
    req(1'b0, 8'd0, 9'd0);
    chk("err_zero", err, 1);
    step();
    req(1'b1, 8'd255, 9'd511);
    chk("err_nowrap", err, 1);
    chk("err_nowrap_busy", busy, 0);
    step();
    req(1'b0, 8'd30, 9'd2);
    chk("top_rf_err", err, 0);
    beat(8'd30, 32'd90, 1'b0, 1'b0);
    beat(8'd31, 32'd93, 1'b1, 1'b0);
    fin_check();
    req(1'b1, 8'd255, 9'd1);
    beat(8'd255, 32'hA500_00FF, 1'b1, 1'b1);
    fin_check();

    // abort while beat 3 is valid and ready
    req(1'b0, 8'd0, 9'd8);
    beat(8'd0, 32'd0, 1'b0, 1'b0);
    beat(8'd1, 32'd3, 1'b0, 1'b0);
    step();
    step();
    chk("abort_beat_valid", out_valid, 1);
    chk("abort_beat_index", out_index, 2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_rd_en", rd_en, 0);
    step();
    chk("abort_done_late", done, 0);
    chk("abort_valid_late", out_valid, 0);
    req(1'b0, 8'd4, 9'd1);
    beat(8'd4, 32'd12, 1'b1, 1'b0);
    fin_check();

    // async reset while held in SEND
    out_ready = 1'b0;
    req(1'b0, 8'd0, 9'd4);
    step();
    step();
    chk("pre_reset_valid", out_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_valid", out_valid, 0);
    chk("async_busy", busy, 0);
    chk("async_rd_en", rd_en, 0);
    step();
    reset_n   = 1'b1;
    out_ready = 1'b1;
    chk("async_done", done, 0);
    chk("async_err", err, 0);
    req(1'b1, 8'd5, 9'd1);
    beat(8'd5, 32'hDEADBEEF, 1'b1, 1'b1);
    fin_check();

    // second start while busy is ignored
    req(1'b0, 8'd10, 9'd3);
    beat(8'd10, 32'd30, 1'b0, 1'b0);
    mode  = 1'b1;
    base  = 8'd0;
    count = 9'd1;
    start = 1'b1;
    beat(8'd11, 32'd33, 1'b0, 1'b0);
    start = 1'b0;
    chk("busy_start_err", err, 0);
    beat(8'd12, 32'd36, 1'b1, 1'b0);
    fin_check();
    chk("busy_start_err_end", err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
